// File: rtl/kanagawa_logic_ram_mp.sv
// kanagawa_logic_ram_mp: multi-read/multi-write flop RAM with a post-reset INIT_VALUE sweep.
// Define KANAGAWA_LOGIC_RAM_MP_WR_BYPASS_EN to forward same-edge writes into reads (new-data).
module kanagawa_logic_ram_mp #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DEPTH           = 217,
  parameter int                    ADDR_WIDTH      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int                    NUM_READ_PORTS  = 2,
  parameter int                    NUM_WRITE_PORTS = 2,
  parameter int                    READ_LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE      = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  rdaddr_in,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rddata_out,
  input  logic [NUM_WRITE_PORTS-1:0]            wren_in,
  input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] wraddr_in,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wrdata_in,
  output logic                                 init_done,
  output logic                                 wr_conflict
);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $fatal(1, "kanagawa_logic_ram_mp: READ_LATENCY must be 1 or 2");
    end
    if (NUM_READ_PORTS < 1 || NUM_WRITE_PORTS < 1 || DEPTH < 1) begin : g_bad_ports
      $fatal(1, "kanagawa_logic_ram_mp: DEPTH and port counts must be at least 1");
    end
  endgenerate

  localparam logic [0:0]            ST_INIT   = 1'b0;
  localparam logic [0:0]            ST_READY  = 1'b1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_reg;
  logic [ADDR_WIDTH-1:0] sweep_ptr_reg;
  logic                  ready;

  logic [ADDR_WIDTH-1:0] rd_addr     [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0] rd_in_range;
  logic [DATA_WIDTH-1:0] rd_next     [NUM_READ_PORTS];
  logic [DATA_WIDTH-1:0] stage1_reg  [NUM_READ_PORTS];

  logic [ADDR_WIDTH-1:0] wr_addr     [NUM_WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wr_data     [NUM_WRITE_PORTS];
  logic [NUM_WRITE_PORTS-1:0] wr_ok;
  logic                  conflict_next;

  assign ready = (state_reg == ST_READY);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd_unpack
      assign rd_addr[gi]     = rdaddr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_in_range[gi] = ({1'b0, rd_addr[gi]} < DEPTH_EXT);
    end
    // A write port only counts once the sweep is done and its address is inside the table.
    for (gi = 0; gi < NUM_WRITE_PORTS; gi++) begin : g_wr_unpack
      assign wr_addr[gi] = wraddr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_data[gi] = wrdata_in[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wr_ok[gi]   = ready && wren_in[gi] && ({1'b0, wr_addr[gi]} < DEPTH_EXT);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      sweep_ptr_reg <= '0;
      init_done     <= 1'b0;
    end else if (state_reg == ST_INIT) begin
      if (sweep_ptr_reg == LAST_ADDR) begin
        state_reg <= ST_READY;
        init_done <= 1'b1;
      end else begin
        sweep_ptr_reg <= sweep_ptr_reg + ADDR_WIDTH'(1);
      end
    end
  end

  // Ascending port order means the highest-indexed enabled port lands last and wins.
  always_ff @(posedge clk) begin
    if (rst_n && state_reg == ST_INIT) begin
      mem[sweep_ptr_reg] <= INIT_VALUE;
    end else begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (wr_ok[w]) begin
          mem[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      for (int j = i + 1; j < NUM_WRITE_PORTS; j++) begin
        if (wr_ok[i] && wr_ok[j] && (wr_addr[i] == wr_addr[j])) begin
          conflict_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict_next;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_next[p] = '0;
      if (rd_in_range[p]) begin
        rd_next[p] = mem[rd_addr[p]];
      end
`ifdef KANAGAWA_LOGIC_RAM_MP_WR_BYPASS_EN
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (wr_ok[w] && (wr_addr[w] == rd_addr[p])) begin
          rd_next[p] = wr_data[w];
        end
      end
`endif
    end
  end

  generate
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd_pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage1_reg[gi] <= '0;
        end else begin
          stage1_reg[gi] <= rd_next[gi];
        end
      end

      if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] stage2_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            stage2_reg <= '0;
          end else begin
            stage2_reg <= stage1_reg[gi];
          end
        end
        assign rddata_out[gi*DATA_WIDTH +: DATA_WIDTH] = stage2_reg;
      end else begin : g_lat1
        assign rddata_out[gi*DATA_WIDTH +: DATA_WIDTH] = stage1_reg[gi];
      end
    end
  endgenerate

endmodule
